// File: rtl/bit_serializer_if.sv
// Handshake and data bundle between the serializer, its loader, the external bit
// selector and the serial consumer.
interface bit_serializer_if #(
    parameter int unsigned nrOfInputBits = 8,
    parameter int unsigned nrOfselBits   = 3
);
    logic                     loadValid;
    logic                     loadReady;
    logic [nrOfInputBits-1:0] loadData;
    logic [nrOfselBits-1:0]   loadLen;
    logic                     msbFirst;
    logic                     abort;
    logic [nrOfInputBits-1:0] wordOut;
    logic [nrOfselBits-1:0]   sel;
    logic                     bitIn;
    logic                     serValid;
    logic                     serReady;
    logic                     serData;
    logic                     serLast;
    logic                     done;

    // Serializer side.
    modport slave (
        input  loadValid, loadData, loadLen, msbFirst, abort, bitIn, serReady,
        output loadReady, wordOut, sel, serValid, serData, serLast, done
    );

    // Environment side: loader, bit selector and consumer.
    modport master (
        output loadValid, loadData, loadLen, msbFirst, abort, bitIn, serReady,
        input  loadReady, wordOut, sel, serValid, serData, serLast, done
    );
endinterface

// File: rtl/bit_serializer.sv
// Serializes a loaded parallel word one bit per accepted beat; an external bit selector
// picks wordOut[sel] and returns it on bitIn.
module bit_serializer #(
    parameter int unsigned nrOfInputBits = 8,
    parameter int unsigned nrOfselBits   = 3
) (
    input  logic              clock,
    input  logic              resetN,
    bit_serializer_if.slave   bus
);
    localparam logic [nrOfselBits-1:0] MaxIdx = nrOfselBits'(nrOfInputBits - 1);
    localparam logic [nrOfselBits-1:0] One    = nrOfselBits'(1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e                   state_q, state_d;
    logic [nrOfInputBits-1:0] word_q, word_d;
    logic [nrOfselBits-1:0]   sel_q, sel_d;
    logic [nrOfselBits-1:0]   cnt_q, cnt_d;
    logic [nrOfselBits-1:0]   last_q, last_d;
    logic                     msb_q, msb_d;
    logic                     done_q, done_d;
    logic                     init_q, init_d;

    logic [nrOfselBits-1:0]   len_clamped;
    logic                     is_last;

    assign len_clamped = (bus.loadLen > MaxIdx) ? MaxIdx : bus.loadLen;
    assign is_last     = (cnt_q == last_q);

    // init_q keeps loadReady low until the first edge after reset release.
    assign init_d = 1'b1;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        msb_d   = msb_q;
        done_d  = 1'b0;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.loadValid && init_q) begin
                        word_d  = bus.loadData;
                        last_d  = len_clamped;
                        msb_d   = bus.msbFirst;
                        cnt_d   = '0;
                        sel_d   = bus.msbFirst ? len_clamped : '0;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (bus.serReady) begin
                        if (is_last) begin
                            // sel stays put on the final beat so it never wraps.
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + One;
                            sel_d = msb_q ? (sel_q - One) : (sel_q + One);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            word_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            msb_q   <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            msb_q   <= msb_d;
            done_q  <= done_d;
            init_q  <= init_d;
        end
    end

    assign bus.loadReady = (state_q == StIdle) && init_q;
    assign bus.serValid  = (state_q == StShift);
    assign bus.serLast   = (state_q == StShift) && is_last;
    assign bus.serData   = bus.bitIn;
    assign bus.wordOut   = word_q;
    assign bus.sel       = sel_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: expected beats are queued at load and compared as
// the DUT presents them; the bench models the external bit selector.
module tb_bit_serializer;
    logic clock;
    logic resetN;

    bit_serializer_if #(.nrOfInputBits(8), .nrOfselBits(4)) bif ();

    bit_serializer #(.nrOfInputBits(8), .nrOfselBits(4)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bif)
    );

    // Bit selector model: returns wordOut[sel].
    logic [7:0] sel_shift;
    assign sel_shift = bif.wordOut >> bif.sel;
    assign bif.bitIn = sel_shift[0];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       d;
        logic [3:0] s;
        logic       l;
    } beat_t;

    beat_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic [3:0] len, input logic msb,
                             input bit stall);
        int    lim;
        int    idx;
        int    k;
        beat_t b;
        lim = (len > 4'd7) ? 7 : int'(len);
        @(negedge clock);
        chk("idle_ready", 32'(bif.loadReady), 32'd1);
        chk("idle_valid", 32'(bif.serValid), 32'd0);
        chk("idle_last", 32'(bif.serLast), 32'd0);
        bif.loadValid = 1'b1;
        bif.loadData  = d;
        bif.loadLen   = len;
        bif.msbFirst  = msb;
        bif.serReady  = 1'b0;
        for (int i = 0; i <= lim; i++) begin
            idx = msb ? (lim - i) : i;
            b.d = d[idx];
            b.s = 4'(idx);
            b.l = (i == lim);
            sb.push_back(b);
        end
        @(negedge clock);
        bif.loadValid = 1'b0;
        chk("busy_ready", 32'(bif.loadReady), 32'd0);
        k = 0;
        while (sb.size() > 0 && k < 200) begin
            b = sb[0];
            chk("valid", 32'(bif.serValid), 32'd1);
            chk("sel", 32'(bif.sel), 32'(b.s));
            chk("data", 32'(bif.serData), 32'(b.d));
            chk("last", 32'(bif.serLast), 32'(b.l));
            chk("done_low", 32'(bif.done), 32'd0);
            bif.serReady = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (bif.serReady) void'(sb.pop_front());
            k++;
            @(negedge clock);
        end
        chk("drained", 32'(sb.size()), 32'd0);
        sb.delete();
        bif.serReady = 1'b0;
        chk("done_pulse", 32'(bif.done), 32'd1);
        chk("back_idle", 32'(bif.serValid), 32'd0);
        chk("word_hold", 32'(bif.wordOut), 32'(d));
        @(negedge clock);
        chk("done_once", 32'(bif.done), 32'd0);
        chk("word_hold2", 32'(bif.wordOut), 32'(d));
    endtask

    initial begin
        resetN        = 1'b0;
        bif.loadValid = 1'b0;
        bif.loadData  = '0;
        bif.loadLen   = '0;
        bif.msbFirst  = 1'b0;
        bif.abort     = 1'b0;
        bif.serReady  = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(bif.loadReady), 32'd0);
        chk("rst_valid", 32'(bif.serValid), 32'd0);
        chk("rst_last", 32'(bif.serLast), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_word", 32'(bif.wordOut), 32'd0);
        chk("rst_sel", 32'(bif.sel), 32'd0);
        resetN = 1'b1;
        chk("rel_ready", 32'(bif.loadReady), 32'd0);

        send_word(8'hA5, 4'd7, 1'b1, 1'b0);
        send_word(8'hA5, 4'd3, 1'b0, 1'b0);
        send_word(8'hC3, 4'd7, 1'b0, 1'b1);
        send_word(8'h6E, 4'd15, 1'b1, 1'b0);
        send_word(8'h01, 4'd0, 1'b0, 1'b0);
        send_word(8'h80, 4'd0, 1'b1, 1'b1);

        // Abort on the third beat while a new word is offered.
        @(negedge clock);
        bif.loadValid = 1'b1;
        bif.loadData  = 8'h3C;
        bif.loadLen   = 4'd7;
        bif.msbFirst  = 1'b1;
        @(negedge clock);
        bif.loadValid = 1'b0;
        bif.serReady  = 1'b1;
        repeat (2) @(negedge clock);
        chk("ab_sel", 32'(bif.sel), 32'd5);
        chk("ab_data", 32'(bif.serData), 32'd1);
        bif.abort     = 1'b1;
        bif.loadValid = 1'b1;
        bif.loadData  = 8'hFF;
        bif.loadLen   = 4'd0;
        @(negedge clock);
        chk("ab_idle", 32'(bif.serValid), 32'd0);
        chk("ab_done", 32'(bif.done), 32'd0);
        chk("ab_ready", 32'(bif.loadReady), 32'd1);
        chk("ab_noload", 32'(bif.wordOut), 32'h3C);
        bif.abort     = 1'b0;
        bif.loadValid = 1'b0;
        bif.serReady  = 1'b0;
        @(negedge clock);
        chk("ab_done2", 32'(bif.done), 32'd0);
        chk("ab_idle2", 32'(bif.serValid), 32'd0);

        // Reset pulsed mid-word.
        bif.loadValid = 1'b1;
        bif.loadData  = 8'h96;
        bif.loadLen   = 4'd7;
        bif.msbFirst  = 1'b0;
        @(negedge clock);
        bif.loadValid = 1'b0;
        bif.serReady  = 1'b1;
        @(negedge clock);
        chk("mid_sel", 32'(bif.sel), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("arst_valid", 32'(bif.serValid), 32'd0);
        chk("arst_last", 32'(bif.serLast), 32'd0);
        chk("arst_word", 32'(bif.wordOut), 32'd0);
        chk("arst_sel", 32'(bif.sel), 32'd0);
        chk("arst_done", 32'(bif.done), 32'd0);
        chk("arst_ready", 32'(bif.loadReady), 32'd0);
        bif.serReady = 1'b0;
        @(negedge clock);
        chk("arst_done2", 32'(bif.done), 32'd0);
        resetN = 1'b1;
        chk("rel2_ready", 32'(bif.loadReady), 32'd0);
        send_word(8'h5A, 4'd5, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The module SHALL have parameter nrOfInputBits, default 8, giving the width of the parallel word.
REQ-002 The module SHALL have parameter nrOfselBits, default 3, giving the width of the bit index and the length field; nrOfInputBits SHALL be <= 2**nrOfselBits.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 resetN  input  1  reset, asynchronous and active-low.
REQ-005 loadValid  input  1  a parallel word is offered.
REQ-006 loadReady  output  1  the block accepts a word this cycle.
REQ-007 loadData  input  nrOfInputBits  parallel word to serialize.
REQ-008 loadLen  input  nrOfselBits  number of bits to send minus one.
REQ-009 msbFirst  input  1  direction, sampled at load: 1 sends from the top index down, 0 from index 0 up.
REQ-010 abort  input  1  synchronous cancel of the word in progress.
REQ-011 wordOut  output  nrOfInputBits  held word, driven to the downstream bit selector's data input.
REQ-012 sel  output  nrOfselBits  current bit index, driven to the bit selector's select input.
REQ-013 bitIn  input  1  selected bit returned from the bit selector's output.
REQ-014 serValid  output  1  serial bit available.
REQ-015 serReady  input  1  consumer takes the serial bit.
REQ-016 serData  output  1  serial bit; combinational copy of bitIn.
REQ-017 serLast  output  1  current bit is the final bit of the word.
REQ-018 done  output  1  one-cycle pulse after the final bit is accepted.

Function
REQ-019 The block SHALL implement a two-state FSM, IDLE and SHIFT.
REQ-020 In IDLE, loadReady SHALL be 1, serValid 0 and serLast 0.
REQ-021 In SHIFT, loadReady SHALL be 0 and serValid 1.
REQ-022 A load SHALL occur when loadValid=1 and loadReady=1 on a clock edge. It SHALL capture loadData into wordOut, capture lastIdx = min(loadLen, nrOfInputBits-1), capture msbFirst, clear the beat count and enter SHIFT.
REQ-023 On load, sel SHALL be set to lastIdx when msbFirst=1, and to 0 otherwise.
REQ-024 The first serial bit SHALL be valid in the cycle after the load edge, giving a latency of 1 cycle.
REQ-025 serData SHALL equal bitIn combinationally.
REQ-026 serLast SHALL be 1 in SHIFT exactly when the beat count equals lastIdx.
REQ-027 A beat SHALL be accepted on an edge where serValid=1 and serReady=1.
REQ-028 On an accepted beat that is not the last, the beat count SHALL increment by 1, and sel SHALL decrement by 1 (msbFirst) or increment by 1 (lsbFirst).
REQ-029 sel SHALL never wrap past 0 or past lastIdx.
REQ-030 On an accepted last beat, the FSM SHALL return to IDLE and done SHALL be 1 for exactly the next cycle.
REQ-031 While serReady=0 in SHIFT, sel, wordOut and the beat count SHALL hold, and serValid SHALL stay 1.
REQ-032 abort=1 on an edge SHALL force IDLE without asserting done; abort SHALL take priority over beat acceptance and over load.
REQ-033 A load SHALL NOT be accepted on the same edge as a last-beat acceptance, leaving a mandatory one-cycle IDLE gap.
REQ-034 wordOut SHALL hold its value in IDLE until the next load.
REQ-035 With loadLen=0 the block SHALL send exactly one bit, with serLast=1 on the first beat.

Reset
REQ-036 While resetN=0, the FSM SHALL be in IDLE; wordOut, sel, the beat count, lastIdx, done, serValid and serLast SHALL be 0; and loadReady SHALL be 0.
REQ-037 loadReady SHALL go to 1 in the first cycle after resetN deasserts.
REQ-038 Reset asserted mid-word SHALL discard the word immediately, with no done pulse.

Verification
REQ-039 Load 0xA5, loadLen=7, msbFirst=1, serReady held 1 -> serData sequence 1,0,1,0,0,1,0,1; sel 7 down to 0; serLast on the 8th beat; done pulses the cycle after.
REQ-040 Load 0xA5, loadLen=3, msbFirst=0 -> bits 1,0,1,0; sel 0..3; serLast on the 4th beat.
REQ-041 serReady toggling 1,0,0,1,... -> no bit skipped or repeated; sel frozen during stalls.
REQ-042 loadLen=15 with nrOfInputBits=8 -> clamped to 8 beats.
REQ-043 abort on beat 3 together with loadValid=1 -> IDLE, no done, load not taken, loadReady=1 next cycle.
REQ-044 resetN pulsed low mid-word -> all outputs 0 asynchronously; after release a fresh load serializes correctly.
